// File: rtl/shutter_phase_gen_pkg.sv
// rtl/shutter_phase_gen_pkg.sv - shared state encoding and default timing for the shutter phase generator
package shutter_phase_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2,
    S_COAST   = 2'd3
  } state_t;

  localparam int DEF_W          = 8;
  localparam int DEF_DEAD       = 4;
  localparam int DEF_TOL        = 8;
  localparam int DEF_LOCK_EDGES = 4;
  localparam int DEF_MAX_MISS   = 3;

endpackage

// File: rtl/shutter_phase_gen_flywheel.sv
// rtl/shutter_phase_gen_flywheel.sv - phase counter that anchors on sync edges and coasts at the filtered period
module shutter_phase_gen_flywheel #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         anchor,
  input  logic         anchor_eye,
  input  logic         clear,
  input  logic [W-1:0] period,
  output logic [W-1:0] phase,
  output logic         eye,
  output logic         wrap
);

  // Compare with >= so a period that shrinks below the current phase wraps next cycle.
  assign wrap = (phase >= (period - W'(1)));

  // Clear holds the wheel at zero; an edge re-anchors; otherwise count and flip eye at each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      eye   <= 1'b0;
    end else if (clear) begin
      phase <= '0;
    end else if (anchor) begin
      phase <= '0;
      eye   <= anchor_eye;
    end else if (wrap) begin
      phase <= '0;
      eye   <= ~eye;
    end else begin
      phase <= phase + W'(1);
    end
  end

endmodule

// File: rtl/shutter_phase_gen.sv
// rtl/shutter_phase_gen.sv - lock FSM and dead-time shutter decode driven by the phase flywheel
module shutter_phase_gen
  import shutter_phase_gen_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int DEAD       = DEF_DEAD,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_EDGES = DEF_LOCK_EDGES,
  parameter int MAX_MISS   = DEF_MAX_MISS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         edge_signal,
  input  logic         signal,
  input  logic [W-1:0] average,
  input  logic         error,
  output logic         left_open,
  output logic         right_open,
  output logic         locked,
  output logic [1:0]   miss_cnt
);

  localparam int GW = $clog2(LOCK_EDGES + 1);

  state_t          state, state_n;
  logic [GW-1:0]   good_cnt, good_cnt_n;
  logic [1:0]      miss_n;
  logic            anchor, clear;
  logic [W-1:0]    phase;
  logic            eye, wrap;
  logic            period_ok, edge_good, open_eye;
  logic [W:0]      arrival, span, delta;

  shutter_phase_gen_flywheel #(.W(W)) u_flywheel (
    .clk        (clk),
    .rst_n      (rst_n),
    .anchor     (anchor),
    .anchor_eye (signal),
    .clear      (clear),
    .period     (average),
    .phase      (phase),
    .eye        (eye),
    .wrap       (wrap)
  );

  // Shortest period that still leaves an open window after both dead zones.
  assign period_ok = (average >= W'(2 * DEAD + 2));

  // Edge quality: arrival distance from the expected period, one extra bit so nothing wraps.
  assign arrival   = {1'b0, phase} + (W + 1)'(1);
  assign span      = {1'b0, average};
  assign delta     = (arrival >= span) ? (arrival - span) : (span - arrival);
  assign edge_good = (delta <= (W + 1)'(TOL));

  assign open_eye = ((state == S_LOCKED) || (state == S_COAST)) && period_ok && !error &&
                    (phase >= W'(DEAD)) && (phase < (average - W'(DEAD)));

  // Next-state logic; a bad period or timeout drops everything back to IDLE.
  always_comb begin
    state_n    = state;
    good_cnt_n = good_cnt;
    miss_n     = miss_cnt;
    anchor     = 1'b0;
    clear      = 1'b0;
    if (!period_ok || error) begin
      state_n    = S_IDLE;
      good_cnt_n = '0;
      miss_n     = 2'd0;
      clear      = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (edge_signal) begin
            state_n    = S_ACQUIRE;
            good_cnt_n = GW'(1);
            anchor     = 1'b1;
          end else begin
            clear = 1'b1;
          end
        end
        S_ACQUIRE: begin
          if (edge_signal) begin
            anchor = 1'b1;
            if (edge_good) begin
              good_cnt_n = good_cnt + GW'(1);
              if (good_cnt_n == GW'(LOCK_EDGES)) state_n = S_LOCKED;
            end else begin
              good_cnt_n = GW'(1);
            end
          end else if (wrap) begin
            state_n    = S_IDLE;
            good_cnt_n = '0;
            clear      = 1'b1;
          end
        end
        S_LOCKED: begin
          if (edge_signal && edge_good) begin
            anchor = 1'b1;
            miss_n = 2'd0;
          end else if (edge_signal || wrap) begin
            state_n = S_COAST;
            miss_n  = 2'd1;
          end
        end
        S_COAST: begin
          if (edge_signal && edge_good) begin
            anchor  = 1'b1;
            miss_n  = 2'd0;
            state_n = S_LOCKED;
          end else if (edge_signal || wrap) begin
            if (miss_cnt == 2'(MAX_MISS)) begin
              state_n    = S_IDLE;
              miss_n     = 2'd0;
              good_cnt_n = '0;
              clear      = 1'b1;
            end else begin
              miss_n = miss_cnt + 2'd1;
            end
          end
        end
        default: begin
          state_n = S_IDLE;
          clear   = 1'b1;
        end
      endcase
    end
  end

  // State, counters and registered output pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      good_cnt   <= '0;
      miss_cnt   <= 2'd0;
      left_open  <= 1'b0;
      right_open <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      good_cnt   <= good_cnt_n;
      miss_cnt   <= miss_n;
      left_open  <= open_eye & eye;
      right_open <= open_eye & ~eye;
      locked     <= (state == S_LOCKED) || (state == S_COAST);
    end
  end

endmodule

// File: tb/tb_shutter_phase_gen.sv
// tb/tb_shutter_phase_gen.sv - directed self-checking bench for shutter_phase_gen
module tb_shutter_phase_gen;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         edge_signal;
  logic         signal;
  logic [W-1:0] average;
  logic         error;
  logic         left_open;
  logic         right_open;
  logic         locked;
  logic [1:0]   miss_cnt;

  int checks = 0;
  int errors = 0;

  shutter_phase_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .edge_signal (edge_signal),
    .signal      (signal),
    .average     (average),
    .error       (error),
    .left_open   (left_open),
    .right_open  (right_open),
    .locked      (locked),
    .miss_cnt    (miss_cnt)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic s);
    edge_signal = 1'b1;
    signal      = s;
    tick();
    edge_signal = 1'b0;
  endtask

  task automatic lock_seq(input int per);
    pulse(1'b1); idle(per - 1);
    pulse(1'b0); idle(per - 1);
    pulse(1'b1); idle(per - 1);
    pulse(1'b0);
  endtask

  // Walk one frame right after an anchor; pins lag the phase by one cycle.
  task automatic frame_check(input int per, input logic exp_left);
    logic op;
    for (int j = 1; j < per; j++) begin
      tick();
      op = ((j - 1) >= 4) && ((j - 1) < (per - 4));
      check("frame_left",   {7'd0, left_open},  {7'd0, op & exp_left});
      check("frame_right",  {7'd0, right_open}, {7'd0, op & ~exp_left});
      check("frame_locked", {7'd0, locked},     8'd1);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    edge_signal = 1'b0;
    signal      = 1'b0;
    average     = 8'd100;
    error       = 1'b0;
    #1;
    check("rst_left",   {7'd0, left_open},  8'd0);
    check("rst_right",  {7'd0, right_open}, 8'd0);
    check("rst_locked", {7'd0, locked},     8'd0);
    check("rst_miss",   {6'd0, miss_cnt},   8'd0);
    #20 rst_n = 1'b1;
    tick();
    check("idle_locked", {7'd0, locked}, 8'd0);

    // Acquire with edges 100 ticks apart; shutters stay closed until locked.
    pulse(1'b1); idle(50);
    check("acq_left",   {7'd0, left_open},  8'd0);
    check("acq_right",  {7'd0, right_open}, 8'd0);
    check("acq_locked", {7'd0, locked},     8'd0);
    idle(49);
    pulse(1'b0); idle(99);
    pulse(1'b1); idle(99);
    pulse(1'b0);
    check("lock4_pin_lag", {7'd0, locked}, 8'd0);
    frame_check(100, 1'b0);
    pulse(1'b1);
    frame_check(100, 1'b1);

    // Drop two edges: flywheel coasts and toggles eye.
    tick();
    check("coast_miss1", {6'd0, miss_cnt}, 8'd1);
    idle(5);
    check("coast1_right",  {7'd0, right_open}, 8'd1);
    check("coast1_left",   {7'd0, left_open},  8'd0);
    check("coast1_locked", {7'd0, locked},     8'd1);
    idle(94);
    tick();
    check("coast_miss2", {6'd0, miss_cnt}, 8'd2);
    idle(5);
    check("coast2_left", {7'd0, left_open}, 8'd1);
    idle(94);
    // Edge on the wrap cycle with signal=1: eye must stay left.
    pulse(1'b1);
    check("relock_miss", {6'd0, miss_cnt}, 8'd0);
    idle(5);
    check("wrap_edge_left",  {7'd0, left_open},  8'd1);
    check("wrap_edge_right", {7'd0, right_open}, 8'd0);

    // Early edge at tick 80 is ignored: no re-anchor.
    idle(74);
    pulse(1'b0);
    check("bad80_miss", {6'd0, miss_cnt}, 8'd1);
    idle(10);
    check("bad80_noanchor_left",  {7'd0, left_open},  8'd1);
    check("bad80_noanchor_right", {7'd0, right_open}, 8'd0);
    idle(9);
    tick();
    check("bad80_wrap_miss", {6'd0, miss_cnt}, 8'd2);
    idle(92);
    pulse(1'b1);
    check("early7_good", {6'd0, miss_cnt}, 8'd0);
    // Tolerance boundary: 8 early is good, 9 early is bad.
    idle(91);
    pulse(1'b0);
    check("early8_good", {6'd0, miss_cnt}, 8'd0);
    idle(5);
    check("early8_anchor_right", {7'd0, right_open}, 8'd1);
    idle(85);
    pulse(1'b1);
    check("early9_bad", {6'd0, miss_cnt}, 8'd1);
    idle(5);
    check("early9_keep_right", {7'd0, right_open}, 8'd1);
    check("early9_keep_left",  {7'd0, left_open},  8'd0);
    idle(3);
    pulse(1'b1);
    check("resync_miss", {6'd0, miss_cnt}, 8'd0);

    // Drop four edges: IDLE after the fourth wrap.
    for (int k = 1; k <= 3; k++) begin
      idle(99);
      tick();
      check("drop_miss",   {6'd0, miss_cnt}, k[7:0]);
      check("drop_locked", {7'd0, locked},   8'd1);
    end
    idle(99);
    tick();
    check("drop4_miss", {6'd0, miss_cnt}, 8'd0);
    tick();
    check("drop4_locked", {7'd0, locked},     8'd0);
    check("drop4_left",   {7'd0, left_open},  8'd0);
    check("drop4_right",  {7'd0, right_open}, 8'd0);

    // Comparator timeout mid-frame.
    lock_seq(100);
    idle(50);
    check("err_pre_right", {7'd0, right_open}, 8'd1);
    error = 1'b1;
    tick();
    check("err_right", {7'd0, right_open}, 8'd0);
    check("err_left",  {7'd0, left_open},  8'd0);
    tick();
    check("err_locked", {7'd0, locked}, 8'd0);
    error = 1'b0;
    tick();
    check("err_miss", {6'd0, miss_cnt}, 8'd0);

    // Period below minimum mid-frame.
    lock_seq(100);
    idle(50);
    check("avg9_pre_right", {7'd0, right_open}, 8'd1);
    average = 8'd9;
    tick();
    check("avg9_right", {7'd0, right_open}, 8'd0);
    check("avg9_left",  {7'd0, left_open},  8'd0);
    tick();
    check("avg9_locked", {7'd0, locked}, 8'd0);

    // Asynchronous reset mid-frame.
    average = 8'd100;
    tick();
    lock_seq(100);
    idle(50);
    check("arst_pre_right", {7'd0, right_open}, 8'd1);
    rst_n = 1'b0;
    #2;
    check("arst_right",  {7'd0, right_open}, 8'd0);
    check("arst_locked", {7'd0, locked},     8'd0);
    check("arst_miss",   {6'd0, miss_cnt},   8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_after_locked", {7'd0, locked}, 8'd0);

    // Minimum valid period: open window is phases 4..5 only.
    average = 8'd10;
    tick();
    lock_seq(10);
    frame_check(10, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
